// File: rtl/rd_burst_sched.sv
// rd_burst_sched: read-side burst scheduler for the async FIFO, rclk domain.
// Define RD_BURST_STATS_EN to add the stat_bursts / stat_partial counters.
module rd_burst_sched #(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [ADDR_WIDTH:0]   rptr,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  flush_req,
  output logic                  rinc,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  busy
`ifdef RD_BURST_STATS_EN
  ,
  output logic [15:0]           stat_bursts,
  output logic [15:0]           stat_partial
`endif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [PW-1:0] BURST_LEN_W = PW'(BURST_LEN);
  localparam logic [TW-1:0] TIMER_MAX   = TW'(TIMEOUT_CYC - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [PW-1:0]         beats_left_q, beats_left_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_last_q;
  logic                  start;
  logic [PW-1:0]         start_len;
  logic                  m_accept;
  logic                  burst_done;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The synchronized write pointer lags, so this level can only understate content.
  assign rd_level   = gray2bin(rq2_wptr) - gray2bin(rptr);
  assign busy       = (state_q == S_BURST);
  assign m_accept   = m_valid_q & m_ready;
  assign rinc       = (state_q == S_BURST) & ~rempty & (beats_left_q != '0) &
                      (~m_valid_q | m_ready);
  assign burst_done = (state_q == S_BURST) & (beats_left_q == '0) & m_accept & m_last_q;

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    timer_d      = timer_q;
    start        = 1'b0;
    start_len    = '0;
    case (state_q)
      S_IDLE: begin
        // Full burst wins over flush, flush wins over timeout.
        if (rd_level >= BURST_LEN_W) begin
          start     = 1'b1;
          start_len = BURST_LEN_W;
        end else if (flush_req && (rd_level != '0)) begin
          start     = 1'b1;
          start_len = rd_level;
        end else if (rd_level != '0) begin
          if (timer_q == TIMER_MAX) begin
            start     = 1'b1;
            start_len = rd_level;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end else begin
          timer_d = '0;
        end
        if (start) begin
          state_d      = S_BURST;
          beats_left_d = start_len;
          timer_d      = '0;
        end
      end
      default: begin
        if (rinc) begin
          beats_left_d = beats_left_q - PW'(1);
        end
        if (burst_done) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= S_IDLE;
      beats_left_q <= '0;
      timer_q      <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      timer_q      <= timer_d;
      if (rinc) begin
        m_data_q  <= rdata;
        m_valid_q <= 1'b1;
        m_last_q  <= (beats_left_q == PW'(1));
      end else if (m_accept) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

`ifdef RD_BURST_STATS_EN
  logic [PW-1:0] burst_len_q;
  logic [15:0]   stat_bursts_q;
  logic [15:0]   stat_partial_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      burst_len_q    <= '0;
      stat_bursts_q  <= '0;
      stat_partial_q <= '0;
    end else begin
      if (start) begin
        burst_len_q <= start_len;
      end
      if (burst_done) begin
        stat_bursts_q <= sat_inc16(stat_bursts_q);
        if (burst_len_q < BURST_LEN_W) begin
          stat_partial_q <= sat_inc16(stat_partial_q);
        end
      end
    end
  end

  assign stat_bursts  = stat_bursts_q;
  assign stat_partial = stat_partial_q;
`endif

endmodule
